// File: rtl/grid_pool_x.sv
// grid_pool_x: grid pooling stage that folds each event's feature vector into
// its cell history (max or saturating sum) and reports the pooled vector,
// its delta against the previous history, and cell occupancy.
module grid_pool_x #(
    parameter int unsigned C           = 32,
    parameter int unsigned F_WIDTH     = 8,
    parameter int unsigned LANES       = 8,
    parameter int unsigned SIGNED_F    = 0,
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 8,
    parameter int unsigned CELL_W_LOG2 = 4,
    parameter int unsigned CELL_H_LOG2 = 4,
    parameter int unsigned GRID_X_LOG2 = 3,
    parameter int unsigned GRID_Y_LOG2 = 3
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 event_stream_clean,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [X_W-1:0]                       in_x,
    input  logic [Y_W-1:0]                       in_y,
    input  logic                                 in_mode,
    input  logic [C*F_WIDTH-1:0]                 in_feat,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [GRID_X_LOG2+GRID_Y_LOG2-1:0]   out_grid_idx,
    output logic [C*F_WIDTH-1:0]                 out_x,
    output logic [C*F_WIDTH-1:0]                 out_dx,
    output logic                                 out_first,
    output logic                                 out_err,
    output logic [GRID_X_LOG2+GRID_Y_LOG2:0]     cells_used
);
    localparam int unsigned IDX_W    = GRID_X_LOG2 + GRID_Y_LOG2;
    localparam int unsigned GRID_NUM = 1 << IDX_W;
    localparam int unsigned VW       = C * F_WIDTH;
    localparam int unsigned B        = C / LANES;
    localparam int unsigned BEAT_W   = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned EW       = F_WIDTH + 2;

    localparam logic signed [EW-1:0] S_MAX = EW'((2 ** (F_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] S_MIN = EW'(-(2 ** (F_WIDTH - 1)));
    localparam logic signed [EW-1:0] U_MAX = EW'((2 ** F_WIDTH) - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_COMB, ST_WRITE, ST_OUT} state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  mode_q, mode_d;
    logic [VW-1:0]         feat_q, feat_d;
    logic                  first_q, first_d;
    logic [VW-1:0]         new_q, new_d;
    logic [VW-1:0]         dx_q, dx_d;
    logic [VW-1:0]         rd_data_q, rd_data_d;
    logic [GRID_NUM-1:0]   valid_q, valid_d;
    logic [IDX_W:0]        cells_q, cells_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [IDX_W-1:0]      out_idx_q, out_idx_d;
    logic [VW-1:0]         out_x_q, out_x_d;
    logic [VW-1:0]         out_dx_q, out_dx_d;
    logic                  out_first_q, out_first_d;
    logic                  out_err_q, out_err_d;
    logic [VW-1:0]         mem_q [GRID_NUM];
    logic                  mem_we_c;
    logic [X_W-1:0]        cx_c;
    logic [Y_W-1:0]        cy_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  oor_c;

    // Widen a feature to EW bits honouring signedness.
    function automatic logic signed [EW-1:0] ext(input logic [F_WIDTH-1:0] a);
        if (SIGNED_F != 0) return {{2{a[F_WIDTH-1]}}, a};
        return {2'b00, a};
    endfunction

    // Clamp a widened value to the feature range.
    function automatic logic [F_WIDTH-1:0] sat(input logic signed [EW-1:0] v);
        if (SIGNED_F != 0) begin
            if (v > S_MAX) return S_MAX[F_WIDTH-1:0];
            if (v < S_MIN) return S_MIN[F_WIDTH-1:0];
        end else begin
            if (v > U_MAX) return U_MAX[F_WIDTH-1:0];
            if (v < 0)     return '0;
        end
        return v[F_WIDTH-1:0];
    endfunction

    // New history value for one channel.
    function automatic logic [F_WIDTH-1:0] comb_new(input logic [F_WIDTH-1:0] old,
                                                    input logic [F_WIDTH-1:0] inp,
                                                    input logic first, input logic mode);
        if (first) return inp;
        if (mode)  return sat(ext(old) + ext(inp));
        return (ext(inp) > ext(old)) ? inp : old;
    endfunction

    // Delta of one channel against its previous history.
    function automatic logic [F_WIDTH-1:0] comb_dx(input logic [F_WIDTH-1:0] nw,
                                                   input logic [F_WIDTH-1:0] old,
                                                   input logic first);
        if (first) return nw;
        return sat(ext(nw) - ext(old));
    endfunction

    // Bit offset of lane l within beat b.
    function automatic int unsigned ch_ofs(input logic [BEAT_W-1:0] b, input int unsigned l);
        return (32'(b) * LANES + l) * F_WIDTH;
    endfunction

    // Cell mapping of the presented event.
    always_comb begin
        cx_c  = in_x >> CELL_W_LOG2;
        cy_c  = in_y >> CELL_H_LOG2;
        oor_c = ((cx_c >> GRID_X_LOG2) != '0) || ((cy_c >> GRID_Y_LOG2) != '0);
        idx_c = {cy_c[GRID_Y_LOG2-1:0], cx_c[GRID_X_LOG2-1:0]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        feat_d      = feat_q;
        first_d     = first_q;
        new_d       = new_q;
        dx_d        = dx_q;
        valid_d     = valid_q;
        cells_d     = cells_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_x_d     = out_x_q;
        out_dx_d    = out_dx_q;
        out_first_d = out_first_q;
        out_err_d   = out_err_q;
        mem_we_c    = 1'b0;
        rd_data_d   = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (oor_c) begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_idx_d   = '0;
                        out_x_d     = '0;
                        out_dx_d    = '0;
                        out_first_d = 1'b0;
                    end else begin
                        state_d = ST_READ;
                        idx_d   = idx_c;
                        mode_d  = in_mode;
                        feat_d  = in_feat;
                        first_d = !valid_q[idx_c];
                    end
                end
            end
            ST_READ: begin
                rd_data_d = mem_q[idx_q];
                beat_d    = '0;
                state_d   = ST_COMB;
            end
            ST_COMB: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    new_d[ch_ofs(beat_q, l) +: F_WIDTH] =
                        comb_new(rd_data_q[ch_ofs(beat_q, l) +: F_WIDTH],
                                 feat_q[ch_ofs(beat_q, l) +: F_WIDTH], first_q, mode_q);
                    dx_d[ch_ofs(beat_q, l) +: F_WIDTH] =
                        comb_dx(comb_new(rd_data_q[ch_ofs(beat_q, l) +: F_WIDTH],
                                         feat_q[ch_ofs(beat_q, l) +: F_WIDTH], first_q, mode_q),
                                rd_data_q[ch_ofs(beat_q, l) +: F_WIDTH], first_q);
                end
                if (32'(beat_q) == B - 1) state_d = ST_WRITE;
                else                      beat_d  = beat_q + BEAT_W'(1);
            end
            ST_WRITE: begin
                mem_we_c       = 1'b1;
                valid_d[idx_q] = 1'b1;
                if (first_q) cells_d = cells_q + (IDX_W+1)'(1);
                state_d     = ST_OUT;
                out_valid_d = 1'b1;
                out_idx_d   = idx_q;
                out_x_d     = new_q;
                out_dx_d    = dx_q;
                out_first_d = first_q;
                out_err_d   = 1'b0;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset and stream clean share one path.
    always_ff @(posedge clk) begin
        if (!rstn || event_stream_clean) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            feat_q      <= '0;
            first_q     <= 1'b0;
            new_q       <= '0;
            dx_q        <= '0;
            rd_data_q   <= '0;
            valid_q     <= '0;
            cells_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_x_q     <= '0;
            out_dx_q    <= '0;
            out_first_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            feat_q      <= feat_d;
            first_q     <= first_d;
            new_q       <= new_d;
            dx_q        <= dx_d;
            rd_data_q   <= rd_data_d;
            valid_q     <= valid_d;
            cells_q     <= cells_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_x_q     <= out_x_d;
            out_dx_q    <= out_dx_d;
            out_first_q <= out_first_d;
            out_err_q   <= out_err_d;
        end
    end

    // History RAM write; a clear in the same cycle suppresses it.
    always_ff @(posedge clk) begin
        if (mem_we_c && rstn && !event_stream_clean) mem_q[idx_q] <= new_q;
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_grid_idx = out_idx_q;
    assign out_x        = out_x_q;
    assign out_dx       = out_dx_q;
    assign out_first    = out_first_q;
    assign out_err      = out_err_q;
    assign cells_used   = cells_q;
endmodule

// File: tb/tb_grid_pool_x.sv
// Directed bench for grid_pool_x: an unsigned and a signed instance share stimulus.
module tb_grid_pool_x;
    localparam int VW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, clean, in_valid, in_mode, out_ready;
    logic [7:0]    in_x, in_y;
    logic [VW-1:0] in_feat;
    logic          in_ready, out_valid, out_first, out_err;
    logic [5:0]    out_grid_idx;
    logic [VW-1:0] out_x, out_dx;
    logic [6:0]    cells_used;
    logic          in_ready_s, out_valid_s, out_first_s, out_err_s;
    logic [5:0]    out_grid_idx_s;
    logic [VW-1:0] out_x_s, out_dx_s;
    logic [6:0]    cells_used_s;

    int checks = 0;
    int fails  = 0;

    grid_pool_x u_dut (
        .clk(clk), .rstn(rstn), .event_stream_clean(clean),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_mode(in_mode), .in_feat(in_feat), .out_valid(out_valid), .out_ready(out_ready),
        .out_grid_idx(out_grid_idx), .out_x(out_x), .out_dx(out_dx),
        .out_first(out_first), .out_err(out_err), .cells_used(cells_used)
    );

    grid_pool_x #(.SIGNED_F(1)) u_dut_s (
        .clk(clk), .rstn(rstn), .event_stream_clean(clean),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_x(in_x), .in_y(in_y),
        .in_mode(in_mode), .in_feat(in_feat), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_grid_idx(out_grid_idx_s), .out_x(out_x_s), .out_dx(out_dx_s),
        .out_first(out_first_s), .out_err(out_err_s), .cells_used(cells_used_s)
    );

    function automatic logic [VW-1:0] fill(input logic [7:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < 32; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    // Present an event and return once it is accepted (or the budget expires).
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic m,
                        input logic [VW-1:0] f);
        @(negedge clk);
        in_x = x; in_y = y; in_mode = m; in_feat = f; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    // Edges from the accept edge until out_valid shows; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; clean = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_feat = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_x !== '0 || out_dx !== '0) begin fails++; $display("FAIL rst_vectors got %h / %h want 0", out_x, out_dx); end
        checks++; if ({out_first, out_err, out_grid_idx} !== '0) begin fails++; $display("FAIL rst_flags got %b%b %0d want 0", out_first, out_err, out_grid_idx); end
        checks++; if (cells_used !== 7'd0) begin fails++; $display("FAIL rst_cells got %0d want 0", cells_used); end
    endtask

    task automatic test_first_event();
        int lat;
        send(8'd20, 8'd40, 1'b0, fill(8'd5));
        wait_out(lat);
        checks++; if (lat != 6) begin fails++; $display("FAIL first_latency got %0d want 6", lat); end
        checks++; if (out_grid_idx !== 6'd17) begin fails++; $display("FAIL first_idx got %0d want 17", out_grid_idx); end
        checks++; if (out_x !== fill(8'd5)) begin fails++; $display("FAIL first_x got %h want %h", out_x, fill(8'd5)); end
        checks++; if (out_dx !== fill(8'd5)) begin fails++; $display("FAIL first_dx got %h want %h", out_dx, fill(8'd5)); end
        checks++; if (out_first !== 1'b1 || out_err !== 1'b0) begin fails++; $display("FAIL first_flags got first=%b err=%b want 1 0", out_first, out_err); end
        checks++; if (cells_used !== 7'd1) begin fails++; $display("FAIL first_cells got %0d want 1", cells_used); end
        consume();
    endtask

    task automatic test_max_update();
        int lat;
        logic [VW-1:0] f, ex, ed;
        f = '0; f[7:0] = 8'd9; f[15:8] = 8'd3;
        ex = fill(8'd5); ex[7:0] = 8'd9;
        ed = '0; ed[7:0] = 8'd4;
        send(8'd20, 8'd40, 1'b0, f);
        wait_out(lat);
        checks++; if (out_x !== ex) begin fails++; $display("FAIL max_x got %h want %h", out_x, ex); end
        checks++; if (out_dx !== ed) begin fails++; $display("FAIL max_dx got %h want %h", out_dx, ed); end
        checks++; if (out_first !== 1'b0 || cells_used !== 7'd1) begin fails++; $display("FAIL max_first_cells got %b %0d want 0 1", out_first, cells_used); end
        consume();
    endtask

    task automatic test_sum_sat();
        int lat;
        send(8'd0, 8'd0, 1'b0, fill(8'd200));
        wait_out(lat);
        consume();
        send(8'd0, 8'd0, 1'b1, fill(8'd100));
        wait_out(lat);
        checks++; if (lat != 6) begin fails++; $display("FAIL sum_latency got %0d want 6", lat); end
        checks++; if (out_x !== fill(8'd255)) begin fails++; $display("FAIL sum_x got %h want %h", out_x, fill(8'd255)); end
        checks++; if (out_dx !== fill(8'd55)) begin fails++; $display("FAIL sum_dx got %h want %h", out_dx, fill(8'd55)); end
        checks++; if (out_grid_idx !== 6'd0 || cells_used !== 7'd2) begin fails++; $display("FAIL sum_idx_cells got %0d %0d want 0 2", out_grid_idx, cells_used); end
        consume();
    endtask

    task automatic test_signed();
        int lat;
        send(8'd16, 8'd0, 1'b0, fill(8'h9C));
        wait_out(lat);
        consume();
        send(8'd16, 8'd0, 1'b1, fill(8'h9C));
        wait_out(lat);
        checks++; if (out_valid_s !== out_valid) begin fails++; $display("FAIL signed_lockstep got %b want %b", out_valid_s, out_valid); end
        checks++; if (out_x_s !== fill(8'h80)) begin fails++; $display("FAIL ssum_x got %h want %h", out_x_s, fill(8'h80)); end
        checks++; if (out_dx_s !== fill(8'hE4)) begin fails++; $display("FAIL ssum_dx got %h want %h", out_dx_s, fill(8'hE4)); end
        checks++; if (out_x !== fill(8'hFF) || out_dx !== fill(8'h63)) begin fails++; $display("FAIL usum_xdx got %h / %h want ff.. / 63..", out_x, out_dx); end
        consume();
        send(8'd16, 8'd0, 1'b0, fill(8'd5));
        wait_out(lat);
        checks++; if (out_x_s !== fill(8'h05)) begin fails++; $display("FAIL smax_x got %h want %h", out_x_s, fill(8'h05)); end
        checks++; if (out_dx_s !== fill(8'h7F)) begin fails++; $display("FAIL smax_dx got %h want %h", out_dx_s, fill(8'h7F)); end
        checks++; if (out_x !== fill(8'hFF) || out_dx !== '0) begin fails++; $display("FAIL umax_xdx got %h / %h want ff.. / 0", out_x, out_dx); end
        checks++; if (cells_used_s !== 7'd3 || cells_used !== 7'd3) begin fails++; $display("FAIL signed_cells got %0d %0d want 3 3", cells_used_s, cells_used); end
        consume();
    endtask

    task automatic test_out_of_range();
        int lat;
        send(8'd130, 8'd0, 1'b0, fill(8'd1));
        wait_out(lat);
        checks++; if (lat != 0) begin fails++; $display("FAIL oor_latency got %0d want 0", lat); end
        checks++; if (out_err !== 1'b1 || out_first !== 1'b0) begin fails++; $display("FAIL oor_flags got err=%b first=%b want 1 0", out_err, out_first); end
        checks++; if (out_x !== '0 || out_dx !== '0 || out_grid_idx !== '0) begin fails++; $display("FAIL oor_zero got %h / %h / %0d want 0", out_x, out_dx, out_grid_idx); end
        checks++; if (cells_used !== 7'd3) begin fails++; $display("FAIL oor_cells got %0d want 3", cells_used); end
        consume();
        send(8'd0, 8'd0, 1'b0, fill(8'd0));
        wait_out(lat);
        checks++; if (lat != 6) begin fails++; $display("FAIL post_oor_latency got %0d want 6", lat); end
        checks++; if (out_err !== 1'b0 || out_first !== 1'b0) begin fails++; $display("FAIL post_oor_flags got err=%b first=%b want 0 0", out_err, out_first); end
        checks++; if (out_x !== fill(8'd255) || out_dx !== '0) begin fails++; $display("FAIL post_oor_xdx got %h / %h want ff.. / 0", out_x, out_dx); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [VW-1:0] ex, ed;
        ex = fill(8'd5); ex[7:0] = 8'd9;
        out_ready = 1'b0;
        send(8'd20, 8'd40, 1'b0, fill(8'd1));
        wait_out(lat);
        checks++; if (lat != 6) begin fails++; $display("FAIL bp_latency got %0d want 6", lat); end
        in_x = 8'd20; in_y = 8'd40; in_mode = 1'b0; in_feat = fill(8'd7); in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_x !== ex || out_dx !== '0) begin fails++; $display("FAIL bp_hold[%0d] got %h / %h", i, out_x, out_dx); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b want 0", out_valid); end
        send(8'd20, 8'd40, 1'b0, fill(8'd7));
        wait_out(lat);
        ex = fill(8'd7); ex[7:0] = 8'd9;
        ed = fill(8'd2); ed[7:0] = 8'd0;
        checks++; if (lat != 6) begin fails++; $display("FAIL bp_next_latency got %0d want 6", lat); end
        checks++; if (out_x !== ex || out_dx !== ed) begin fails++; $display("FAIL bp_next_xdx got %h / %h", out_x, out_dx); end
        consume();
    endtask

    task automatic test_clean();
        int lat;
        bit seen;
        send(8'd20, 8'd40, 1'b0, fill(8'd3));
        @(posedge clk);
        #1 clean = 1'b1;
        @(posedge clk);
        #1 clean = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL clean_idle got ready=%b valid=%b want 1 0", in_ready, out_valid); end
        checks++; if (cells_used !== 7'd0) begin fails++; $display("FAIL clean_cells got %0d want 0", cells_used); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL clean_no_output got %b want 0", seen); end
        send(8'd20, 8'd40, 1'b0, fill(8'd3));
        wait_out(lat);
        checks++; if (out_first !== 1'b1 || cells_used !== 7'd1) begin fails++; $display("FAIL clean_first got %b %0d want 1 1", out_first, cells_used); end
        checks++; if (out_x !== fill(8'd3) || out_dx !== fill(8'd3)) begin fails++; $display("FAIL clean_xdx got %h / %h want 03..", out_x, out_dx); end
        consume();
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_max_update();
        test_sum_sat();
        test_signed();
        test_out_of_range();
        test_backpressure();
        test_clean();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
